io_write_ctrl: RTL and testbench

Output-side I/O controller: the write counterpart of the CPU's I/O read multiplexer. It accepts 16-bit CPU I/O writes qualified by `LEDCtrl`/`SegCtrl` decode strobes and holds the values in registers. It drives 16 LEDs and scans a 4-digit common-anode seven-segment display showing the stored word in hex. It sits between the memory/IO address decoder and the board's LED/segment pins.

---
 rtl/io_write_pkg.sv | 18 +
 rtl/seg_hex_decoder.sv | 11 +
 rtl/io_write_ctrl.sv | 133 +++++++++++++
 tb/tb_io_write_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/io_write_pkg.sv
// Shared constants and types for the I/O write controller and its
// seven-segment scanner.
package io_write_pkg;

    localparam int IO_DATA_W  = 16;
    localparam int SEG_DIGITS = 4;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a} patterns, entry 15 (F) first down to entry 0.
    localparam logic [15:0][7:0] HEX_SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef logic [1:0] dig_idx_t;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern (dp always off).
module seg_hex_decoder
    import io_write_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_seg
);

    assign o_seg = HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/io_write_ctrl.sv
// CPU I/O write side: LED register plus a 4-digit multiplexed hex display.
// Optional LED blink mask is built only when IO_WRITE_BLINK_EN is defined.
module io_write_ctrl
    import io_write_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iowrite,
    input  logic                  LEDCtrl,
    input  logic                  SegCtrl,
`ifdef IO_WRITE_BLINK_EN
    input  logic                  BlinkCtrl,
`endif
    input  logic [IO_DATA_W-1:0]  iowrite_data,
    output logic                  write_ack,
    output logic [IO_DATA_W-1:0]  led_out,
    output logic [SEG_DIGITS-1:0] seg_an,
    output logic [7:0]            seg_out
);

    localparam int PRE_W = $clog2(SCAN_DIV);

    generate
        if (SCAN_DIV < 2 || BLINK_DIV < 1) begin : g_bad_param
            $error("io_write_ctrl: SCAN_DIV must be >= 2 and BLINK_DIV >= 1");
        end
    endgenerate

    logic [IO_DATA_W-1:0]  r_led_reg;
    logic [IO_DATA_W-1:0]  r_seg_reg;
    logic                  r_write_ack;
    logic [PRE_W-1:0]      r_pre_cnt;
    dig_idx_t              r_dig_idx;
    logic [SEG_DIGITS-1:0] r_seg_an;
    logic [7:0]            r_seg_out;

    logic                  w_blink_sel;
    logic                  w_accept;
    logic                  w_pre_wrap;
    logic [3:0]            w_nibble;
    logic [7:0]            w_seg_pat;
    logic [SEG_DIGITS-1:0] w_an_pat;

`ifdef IO_WRITE_BLINK_EN
    assign w_blink_sel = BlinkCtrl;
`else
    assign w_blink_sel = 1'b0;
`endif

    // iowrite is a one-cycle strobe with no backpressure: it is accepted in any
    // cycle a decode line is high, and write_ack pulses in the following cycle.
    assign w_accept   = iowrite & (LEDCtrl | SegCtrl | w_blink_sel);
    assign w_pre_wrap = (r_pre_cnt == PRE_W'(SCAN_DIV - 1));
    assign w_nibble   = r_seg_reg[{r_dig_idx, 2'b00} +: 4];
    assign w_an_pat   = ~(SEG_DIGITS'(1) << r_dig_idx);

    seg_hex_decoder u_hex (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_pat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led_reg   <= '0;
            r_seg_reg   <= '0;
            r_write_ack <= 1'b0;
            r_pre_cnt   <= '0;
            r_dig_idx   <= '0;
            r_seg_an    <= '1;
            r_seg_out   <= SEG_BLANK;
        end else begin
            r_write_ack <= w_accept;
            if (iowrite && LEDCtrl) begin
                r_led_reg <= iowrite_data;
            end else if (iowrite && SegCtrl) begin
                r_seg_reg <= iowrite_data;
            end
            // Scan timing is free-running; writes never disturb it.
            if (w_pre_wrap) begin
                r_pre_cnt <= '0;
                r_dig_idx <= r_dig_idx + 2'd1;
            end else begin
                r_pre_cnt <= r_pre_cnt + PRE_W'(1);
            end
            r_seg_an  <= w_an_pat;
            r_seg_out <= w_seg_pat;
        end
    end

`ifdef IO_WRITE_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [IO_DATA_W-1:0] r_blink_mask;
    logic [BLINK_W-1:0]   r_blink_cnt;
    logic                 r_blink_phase;
    logic                 w_round_done;

    // A scan round completes when digit 3's last prescaler cycle wraps.
    assign w_round_done = w_pre_wrap && (r_dig_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_mask  <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (iowrite && BlinkCtrl && !LEDCtrl && !SegCtrl) begin
                r_blink_mask <= iowrite_data;
            end
            if (w_round_done) begin
                if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
                end
            end
        end
    end

    assign led_out = r_led_reg & ~(r_blink_mask & {IO_DATA_W{r_blink_phase}});
`else
    assign led_out = r_led_reg;
`endif

    assign write_ack = r_write_ack;
    assign seg_an    = r_seg_an;
    assign seg_out   = r_seg_out;

endmodule

// File: tb/tb_io_write_ctrl.sv
// Self-checking bench for io_write_ctrl: directed writes against a cycle model
// derived from elapsed time since reset, plus hand-computed literal checks.
module tb_io_write_ctrl;

`ifdef IO_WRITE_BLINK_EN
    localparam int SD = 2;
    localparam int BD = 1;
`else
    localparam int SD = 4;
    localparam int BD = 64;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iowrite = 1'b0;
    logic        led_c = 1'b0;
    logic        seg_c = 1'b0;
    logic        blink_c = 1'b0;
    logic [15:0] wdata = 16'h0;
    logic        write_ack;
    logic [15:0] led_out;
    logic [3:0]  seg_an;
    logic [7:0]  seg_out;

    always #5 clk = ~clk;

    io_write_ctrl #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk          (clk),
        .rst          (rst),
        .iowrite      (iowrite),
        .LEDCtrl      (led_c),
        .SegCtrl      (seg_c),
`ifdef IO_WRITE_BLINK_EN
        .BlinkCtrl    (blink_c),
`endif
        .iowrite_data (wdata),
        .write_ack    (write_ack),
        .led_out      (led_out),
        .seg_an       (seg_an),
        .seg_out      (seg_out)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hC0; 4'h1: hex7 = 8'hF9; 4'h2: hex7 = 8'hA4; 4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99; 4'h5: hex7 = 8'h92; 4'h6: hex7 = 8'h82; 4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80; 4'h9: hex7 = 8'h90; 4'hA: hex7 = 8'h88; 4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6; 4'hD: hex7 = 8'hA1; 4'hE: hex7 = 8'h86; default: hex7 = 8'h8E;
        endcase
    endfunction

    // Model: m_k counts clock edges since reset was released; the digit shown
    // after edge k is ((k-1)/SD) mod 4, using the stored word from before edge k.
    bit          m_valid = 1'b0;
    int          m_k;
    logic [15:0] m_led, m_seg, m_mask;
    logic [15:0] exp_led;
    logic [3:0]  exp_an;
    logic [7:0]  exp_seg;
    logic        exp_ack;

    always @(posedge clk) begin
        int d;
        logic phase;
        if (rst) begin
            m_k = 0; m_led = '0; m_seg = '0; m_mask = '0;
            exp_an = 4'hF; exp_seg = 8'hFF; exp_ack = 1'b0;
        end else begin
            m_k++;
            d = ((m_k - 1) / SD) % 4;
            exp_an  = ~(4'b0001 << d);
            exp_seg = hex7(m_seg[d*4 +: 4]);
            exp_ack = iowrite && (led_c || seg_c || blink_c);
            if (iowrite && led_c)        m_led  = wdata;
            else if (iowrite && seg_c)   m_seg  = wdata;
            else if (iowrite && blink_c) m_mask = wdata;
        end
        phase = (((m_k / (4 * SD)) / BD) % 2) == 1;
        exp_led = m_led & ~(m_mask & {16{phase}});
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model led_out", led_out, exp_led);
            check("model write_ack", {15'b0, write_ack}, {15'b0, exp_ack});
            check("model seg_an", {12'b0, seg_an}, {12'b0, exp_an});
            check("model seg_out", {8'b0, seg_out}, {8'b0, exp_seg});
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic l, input logic s, input logic b, input logic [15:0] d);
        iowrite = 1'b1; led_c = l; seg_c = s; blink_c = b; wdata = d;
        step();
        iowrite = 1'b0; led_c = 1'b0; seg_c = 1'b0; blink_c = 1'b0;
    endtask

    initial begin
        int c0, c1, c2, c3;
        rst = 1'b1;
        repeat (3) step();
        check("reset led_out", led_out, 16'h0000);
        check("reset seg_an", {12'b0, seg_an}, 16'h000F);
        check("reset seg_out", {8'b0, seg_out}, 16'h00FF);
        rst = 1'b0;
        step();
        check("first seg_an", {12'b0, seg_an}, 16'h000E);
        check("first seg_out", {8'b0, seg_out}, 16'h00C0);

        wr(1'b1, 1'b0, 1'b0, 16'hA5A5);
        check("led write", led_out, 16'hA5A5);
        check("led ack", {15'b0, write_ack}, 16'h0001);
        step();
        check("led ack drop", {15'b0, write_ack}, 16'h0000);

        wr(1'b0, 1'b1, 1'b0, 16'h1F80);
        c0 = 0; c1 = 0; c2 = 0; c3 = 0;
        for (int i = 0; i < 4 * SD; i++) begin
            step();
            if (seg_an == 4'hE && seg_out == 8'hC0) c0++;
            if (seg_an == 4'hD && seg_out == 8'h80) c1++;
            if (seg_an == 4'hB && seg_out == 8'h8E) c2++;
            if (seg_an == 4'h7 && seg_out == 8'hF9) c3++;
        end
        check("digit0 cycles", 16'(c0), 16'(SD));
        check("digit1 cycles", 16'(c1), 16'(SD));
        check("digit2 cycles", 16'(c2), 16'(SD));
        check("digit3 cycles", 16'(c3), 16'(SD));

        wr(1'b1, 1'b1, 1'b0, 16'h1234);
        check("simul led", led_out, 16'h1234);
        check("simul ack", {15'b0, write_ack}, 16'h0001);
        repeat (4 * SD) step();

        wr(1'b0, 1'b0, 1'b0, 16'hBEEF);
        check("nodecode ack", {15'b0, write_ack}, 16'h0000);
        check("nodecode led", led_out, 16'h1234);
        repeat (4 * SD) step();

        iowrite = 1'b1; led_c = 1'b1; wdata = 16'h0001;
        step();
        check("b2b ack1", {15'b0, write_ack}, 16'h0001);
        wdata = 16'h0002;
        step();
        check("b2b led2", led_out, 16'h0002);
        led_c = 1'b0; seg_c = 1'b1; wdata = 16'h4321;
        step();
        check("b2b ack3", {15'b0, write_ack}, 16'h0001);
        iowrite = 1'b0; seg_c = 1'b0;
        repeat (4 * SD + 3) step();

`ifdef IO_WRITE_BLINK_EN
        begin
            int n_on, n_off;
            wr(1'b1, 1'b0, 1'b0, 16'hFFFF);
            wr(1'b0, 1'b0, 1'b1, 16'h00FF);
            n_on = 0; n_off = 0;
            for (int i = 0; i < 16; i++) begin
                step();
                if (led_out == 16'hFFFF) n_on++;
                if (led_out == 16'hFF00) n_off++;
            end
            check("blink on cycles", 16'(n_on), 16'd8);
            check("blink off cycles", 16'(n_off), 16'd8);
        end
`endif

        rst = 1'b1; iowrite = 1'b1; led_c = 1'b1; wdata = 16'hFFFF;
        step();
        iowrite = 1'b0; led_c = 1'b0;
        check("rstwr led", led_out, 16'h0000);
        check("rstwr ack", {15'b0, write_ack}, 16'h0000);
        check("rstwr seg_an", {12'b0, seg_an}, 16'h000F);
        check("rstwr seg_out", {8'b0, seg_out}, 16'h00FF);
        rst = 1'b0;
        step();
        check("rstwr first an", {12'b0, seg_an}, 16'h000E);
        check("rstwr first seg", {8'b0, seg_out}, 16'h00C0);
        repeat (4 * SD) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
